// File: rtl/ibtb_update_ctrl.sv
// IBTB update-port sequencer: buffers resolved indirect-branch updates in a small
// FIFO, drains one per cycle, and runs the all-sets invalidation sweep after reset/flush.

package corep;
    typedef logic [37:0] pc38_t;
    typedef logic [15:0] ibtb_gh_t;
    typedef logic [15:0] asid_t;
    typedef struct packed {
        logic        vld;
        logic [1:0]  kind;
        logic [37:0] tgt_pc38;
    } ibtb_info_t;
endpackage

module ibtb_update_ctrl
    import corep::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IBTB_SETS  = 256,
    parameter int INDEX_LSB  = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enq_valid,
    output logic       enq_ready,
    input  pc38_t      enq_src_pc38,
    input  ibtb_gh_t   enq_ibtb_gh,
    input  asid_t      enq_asid,
    input  ibtb_info_t enq_tgt_ibtb_info,
    input  logic       flush_req,
    output logic       sweep_active,
    output logic       update_valid,
    output pc38_t      update_src_pc38,
    output ibtb_gh_t   update_ibtb_gh,
    output asid_t      update_asid,
    output ibtb_info_t update_tgt_ibtb_info
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(IBTB_SETS);

    typedef struct packed {
        pc38_t      pc;
        ibtb_gh_t   gh;
        asid_t      asid;
        ibtb_info_t info;
    } upd_t;

    typedef enum logic {ST_SWEEP, ST_RUN} state_t;

    state_t          state_q;
    logic [IW-1:0]   sweep_idx_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    upd_t            mem_q [FIFO_DEPTH];
    upd_t            out_q;
    logic            out_vld_q;

    logic push, pop, full;
    upd_t enq_upd, sweep_upd;

    // A pop this cycle does not free a slot for a push this cycle.
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign enq_ready = ~RST & ~flush_req & ~full;
    assign push      = enq_valid & enq_ready;
    assign pop       = (state_q == ST_RUN) & ~flush_req & (cnt_q != '0);

    assign enq_upd = '{pc: enq_src_pc38, gh: enq_ibtb_gh, asid: enq_asid,
                       info: enq_tgt_ibtb_info};

    always_comb begin
        sweep_upd    = '0;
        sweep_upd.pc = pc38_t'(sweep_idx_q) << INDEX_LSB;
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= enq_upd;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_vld_q   <= 1'b0;
            out_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase

            // Flush overrides the FIFO bookkeeping above; payload is left holding.
            if (flush_req) begin
                state_q     <= ST_SWEEP;
                sweep_idx_q <= '0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                cnt_q       <= '0;
                out_vld_q   <= 1'b0;
            end else if (state_q == ST_SWEEP) begin
                out_vld_q   <= 1'b1;
                out_q       <= sweep_upd;
                sweep_idx_q <= sweep_idx_q + IW'(1);
                if (sweep_idx_q == IW'(IBTB_SETS - 1)) state_q <= ST_RUN;
            end else if (pop) begin
                out_vld_q <= 1'b1;
                out_q     <= mem_q[rd_ptr_q];
            end else begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign sweep_active         = (state_q == ST_SWEEP);
    assign update_valid         = out_vld_q;
    assign update_src_pc38      = out_q.pc;
    assign update_ibtb_gh       = out_q.gh;
    assign update_asid          = out_q.asid;
    assign update_tgt_ibtb_info = out_q.info;

endmodule

// File: tb/tb_ibtb_update_ctrl.sv
// Scoreboarded bench for ibtb_update_ctrl with an 8-set IBTB and a 4-entry FIFO.

module tb_ibtb_update_ctrl;
    import corep::*;

    localparam int SETS  = 8;
    localparam int DEPTH = 4;
    localparam int LSB   = 2;

    typedef struct packed {
        pc38_t      pc;
        ibtb_gh_t   gh;
        asid_t      asid;
        ibtb_info_t info;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enq_valid = 1'b0;
    logic       enq_ready;
    pc38_t      enq_src_pc38 = '0;
    ibtb_gh_t   enq_ibtb_gh = '0;
    asid_t      enq_asid = '0;
    ibtb_info_t enq_tgt_ibtb_info = '0;
    logic       flush_req = 1'b0;
    logic       sweep_active;
    logic       update_valid;
    pc38_t      update_src_pc38;
    ibtb_gh_t   update_ibtb_gh;
    asid_t      update_asid;
    ibtb_info_t update_tgt_ibtb_info;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    ibtb_update_ctrl #(.FIFO_DEPTH(DEPTH), .IBTB_SETS(SETS), .INDEX_LSB(LSB)) dut (
        .CLK(CLK), .RST(RST),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_src_pc38(enq_src_pc38), .enq_ibtb_gh(enq_ibtb_gh),
        .enq_asid(enq_asid), .enq_tgt_ibtb_info(enq_tgt_ibtb_info),
        .flush_req(flush_req), .sweep_active(sweep_active),
        .update_valid(update_valid), .update_src_pc38(update_src_pc38),
        .update_ibtb_gh(update_ibtb_gh), .update_asid(update_asid),
        .update_tgt_ibtb_info(update_tgt_ibtb_info)
    );

    always #5 CLK = ~CLK;

    // Every issued update must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (update_valid === 1'b1) begin
            exp_t got;
            exp_t e;
            got = '{pc: update_src_pc38, gh: update_ibtb_gh, asid: update_asid,
                    info: update_tgt_ibtb_info};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got pc=%h gh=%h asid=%h info=%h, none expected",
                         got.pc, got.gh, got.asid, got.info);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL update_payload: got pc=%h gh=%h asid=%h info=%h, want pc=%h gh=%h asid=%h info=%h",
                             got.pc, got.gh, got.asid, got.info, e.pc, e.gh, e.asid, e.info);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_sweep();
        for (int k = 0; k < SETS; k++) begin
            exp_t e;
            e = '0;
            e.pc = pc38_t'(k * 4);
            exp_q.push_back(e);
        end
    endtask

    function automatic exp_t mk_entry(int k);
        exp_t e;
        e.pc   = pc38_t'(38'h2000 + k * 16);
        e.gh   = ibtb_gh_t'($urandom);
        e.asid = asid_t'(k + 1);
        e.info = ibtb_info_t'({$urandom, $urandom});
        return e;
    endfunction

    task automatic drive(input exp_t e, input logic v);
        enq_valid         = v;
        enq_src_pc38      = e.pc;
        enq_ibtb_gh       = e.gh;
        enq_asid          = e.asid;
        enq_tgt_ibtb_info = e.info;
    endtask

    // Leaves the bench in cycle N (first cycle with RST low).
    task automatic do_reset();
        enq_valid = 1'b0;
        flush_req = 1'b0;
        RST = 1'b1;
        tick();
        exp_q.delete();
        tick();
        RST = 1'b0;
        push_sweep();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        checks++;
        if ({update_valid, update_src_pc38, enq_ready, sweep_active} !== {1'b0, 38'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got vld=%b pc=%h rdy=%b swp=%b, want 0 0 0 1",
                     update_valid, update_src_pc38, enq_ready, sweep_active);
        end
        exp_q.delete();
        tick();
        RST = 1'b0;
        push_sweep();
        for (int n = 0; n < 10; n++) begin
            #1;
            checks++;
            if (sweep_active !== (n < SETS)) begin
                errors++;
                $display("FAIL reset_sweep_active N+%0d: got %b want %b", n, sweep_active, n < SETS);
            end
            checks++;
            if (update_valid !== (n >= 1 && n <= SETS)) begin
                errors++;
                $display("FAIL reset_sweep_valid N+%0d: got %b want %b", n, update_valid, n >= 1 && n <= SETS);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_sweep_drained: got %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_single();
        exp_t e;
        e = '{pc: 38'h1000, gh: 16'h5a5a, asid: 16'd3, info: '{vld: 1'b1, kind: 2'd2, tgt_pc38: 38'h3_0000_0040}};
        drive(e, 1'b1);
        #1;
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b want 1", enq_ready);
        end
        exp_q.push_back(e);
        tick();
        enq_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            checks++;
            if (update_valid !== (n == 2)) begin
                errors++;
                $display("FAIL single_latency t+%0d: got %b want %b", n, update_valid, n == 2);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drained: got %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        exp_t e;
        do_reset();
        for (int n = 0; n < 15; n++) begin
            if (n < 4) begin
                e = mk_entry(n);
                drive(e, 1'b1);
            end else if (n == 4) begin
                e = mk_entry(n);
                drive(e, 1'b1);
            end else if (n == 10) begin
                enq_valid = 1'b0;
            end
            #1;
            if (n <= 9) begin
                checks++;
                if (enq_ready !== (n < 4 || n == 9)) begin
                    errors++;
                    $display("FAIL full_ready N+%0d: got %b want %b", n, enq_ready, n < 4 || n == 9);
                end
                if (n < 4 || n == 9) exp_q.push_back(e);
            end
            if (n >= 9) begin
                checks++;
                if (update_valid !== (n <= 13)) begin
                    errors++;
                    $display("FAIL full_drain N+%0d: got %b want %b", n, update_valid, n <= 13);
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drained: got %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            exp_t e;
            e = mk_entry(10 + n);
            drive(e, 1'b1);
            exp_q.push_back(e);
            tick();
        end
        enq_valid = 1'b0;
        repeat (5) tick();
        // cycle t = N+9: first entry on the port, three still queued
        checks++;
        if (update_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_valid: got %b want 1", update_valid);
        end
        flush_req = 1'b1;
        drive(mk_entry(99), 1'b1);
        #1;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b want 0", enq_ready);
        end
        @(negedge CLK);
        #1;
        exp_q.delete();
        push_sweep();
        tick();
        flush_req = 1'b0;
        enq_valid = 1'b0;
        for (int n = 1; n <= SETS + 2; n++) begin
            checks++;
            if (update_valid !== (n >= 2 && n <= SETS + 1)) begin
                errors++;
                $display("FAIL flush_sweep_valid t+%0d: got %b want %b", n, update_valid, n >= 2 && n <= SETS + 1);
            end
            if (n == 1) begin
                checks++;
                if (sweep_active !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_sweep_active: got %b want 1", sweep_active);
                end
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_drained: got %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            exp_t e;
            e = mk_entry(20 + k);
            drive(e, 1'b1);
            #1;
            checks++;
            if (enq_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready k=%0d: got %b want 1", k, enq_ready);
            end
            exp_q.push_back(e);
            checks++;
            if (update_valid !== (k >= 2)) begin
                errors++;
                $display("FAIL b2b_valid k=%0d: got %b want %b", k, update_valid, k >= 2);
            end
            tick();
        end
        enq_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (update_valid !== (n < 2)) begin
                errors++;
                $display("FAIL b2b_tail n=%0d: got %b want %b", n, update_valid, n < 2);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drained: got %0d left, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        repeat (5) tick();
        RST = 1'b1;
        @(negedge CLK);
        #1;
        exp_q.delete();
        tick();
        checks++;
        if ({update_valid, update_src_pc38, enq_ready, sweep_active} !== {1'b0, 38'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_state: got vld=%b pc=%h rdy=%b swp=%b, want 0 0 0 1",
                     update_valid, update_src_pc38, enq_ready, sweep_active);
        end
        tick();
        RST = 1'b0;
        push_sweep();
        for (int n = 0; n < 10; n++) begin
            #1;
            checks++;
            if (update_valid !== (n >= 1 && n <= SETS)) begin
                errors++;
                $display("FAIL midreset_sweep N+%0d: got %b want %b", n, update_valid, n >= 1 && n <= SETS);
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_drained: got %0d left, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_flush();
        test_back_to_back();
        test_reset_mid_sweep();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
